// File: rtl/ahb_mem_slave_if.sv
// rtl/ahb_mem_slave_if.sv - AHB-Lite bus bundle between a master and ahb_mem_slave
// Ports (master view):
//   HSEL, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HBURST[2:0], HWDATA[31:0], HREADY  -> slave
//   HRDATA[31:0], HREADYout, HRESP[1:0]                                                    <- slave
`timescale 1ns/1ps
interface ahb_mem_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYout;
  logic [1:0]  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA, HREADYout, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HREADYout, HRESP
  );
endinterface

// File: rtl/ahb_mem_slave.sv
// rtl/ahb_mem_slave.sv - AHB-Lite memory slave with configurable wait states and error responses
// Ports:
//   HCLK     in   clock, all state on rising edge
//   HRESETn  in   asynchronous active-low reset
//   bus      slave modport of ahb_mem_slave_if (address/control/write data in,
//            HRDATA/HREADYout/HRESP out)
`timescale 1ns/1ps
module ahb_mem_slave #(
  parameter logic [31:0] P_ADDR_BASE     = 32'h0000_0000,
  parameter int unsigned P_SIZE_IN_BYTES = 1024,
  parameter int unsigned P_WAIT          = 0
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ahb_mem_slave_if.slave  bus
);

  localparam int unsigned DEPTH     = P_SIZE_IN_BYTES / 4;
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SIZE33    = 33'(P_SIZE_IN_BYTES);
  localparam logic        HAS_WAIT  = (P_WAIT != 0);
  localparam logic [2:0]  WAIT_LOAD = HAS_WAIT ? 3'(P_WAIT - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        hready_q, hready_d;
  logic [1:0]  hresp_q, hresp_d;

  logic [31:0] mem [0:DEPTH-1];

  // Address-phase decode
  logic        accept;
  logic [1:0]  span_m1;
  logic [32:0] offset;
  logic [32:0] offset_last;
  logic        below_base;
  logic        above_top;
  logic        misaligned;
  logic        illegal;

  // Our own ready gates acceptance so a stalled data phase never loses a transfer.
  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hready_q;

  always_comb begin
    span_m1 = 2'd3;
    case (bus.HSIZE)
      3'd0:    span_m1 = 2'd0;
      3'd1:    span_m1 = 2'd1;
      default: span_m1 = 2'd3;
    endcase
  end

  // 33-bit offset: bit 32 is the borrow, i.e. the address lies below the base.
  assign offset      = {1'b0, bus.HADDR} - {1'b0, P_ADDR_BASE};
  assign offset_last = offset + {31'd0, span_m1};
  assign below_base  = offset[32];
  assign above_top   = ~below_base & (offset_last >= SIZE33);
  assign misaligned  = ((bus.HSIZE == 3'd1) & bus.HADDR[0]) |
                       ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00));
  assign illegal     = (bus.HSIZE > 3'd2) | misaligned | below_base | above_top;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all end with HREADYout=1, so a new transfer
        // may be taken here and pipelined straight behind the current one.
        if (accept) begin
          addr_d  = bus.HADDR;
          write_d = bus.HWRITE;
          size_d  = bus.HSIZE[1:0];
          if (illegal) begin
            state_d = S_ERR1;
          end else if (HAS_WAIT) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    hready_d = ~((state_d == S_WAIT) | (state_d == S_ERR1));
    hresp_d  = ((state_d == S_ERR1) | (state_d == S_ERR2)) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      addr_q   <= 32'h0;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  // Data-phase storage access
  logic [31:0]   off_q;
  logic [AW-1:0] idx;
  logic [3:0]    lane_en;

  assign off_q = addr_q - P_ADDR_BASE;
  assign idx   = off_q[AW+1:2];

  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      2'd0:    lane_en[addr_q[1:0]] = 1'b1;
      2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Storage is deliberately not reset; an async reset drops the FSM out of
  // DATA before the next edge, so an interrupted write never lands.
  always_ff @(posedge HCLK) begin
    if ((state_q == S_DATA) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[idx][b*8 +: 8] <= bus.HWDATA[b*8 +: 8];
      end
    end
  end

  // Combinational read port: a write committed at the previous edge is visible
  // immediately, giving zero-wait read-after-write coherency.
  assign bus.HRDATA    = ((state_q == S_DATA) && !write_q) ? mem[idx] : 32'h0;
  assign bus.HREADYout = hready_q;
  assign bus.HRESP     = hresp_q;

  logic unused_bits;
  assign unused_bits = ^{bus.HBURST, bus.HTRANS[0], off_q[31:AW+2], off_q[1:0]};

endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 Parameter P_ADDR_BASE, default 32'h0000_0000: first byte address served.
REQ-002 Parameter P_SIZE_IN_BYTES, default 1024: memory depth in bytes; multiple of 4.
REQ-003 Parameter P_WAIT, default 0, range 0..7: wait states inserted per OKAY data phase.
REQ-004 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-005 HRESETn  input  1  reset; asynchronous assertion, active-low.
REQ-006 HSEL  input  1  slave select, qualifies the address phase.
REQ-007 HADDR  input  32  byte address.
REQ-008 HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 HWRITE  input  1  1=write, 0=read.
REQ-010 HSIZE  input  3  0=byte, 1=halfword, 2=word; others illegal.
REQ-011 HBURST  input  3  burst type; informational only, every beat fully addressed.
REQ-012 HWDATA  input  32  write data, little-endian byte lanes.
REQ-013 HREADY  input  1  bus-wide ready, qualifies the address phase.
REQ-014 HRDATA  output  32  read data.
REQ-015 HREADYout  output  1  this slave's ready.
REQ-016 HRESP  output  2  OKAY=2'b00, ERROR=2'b01.

Function
REQ-017 Transfer accepted at rising edge where HSEL=1, HREADY=1, HTRANS[1]=1; latch HADDR, HWRITE, HSIZE; the following cycle(s) form its data phase.
REQ-018 IDLE/BUSY transfers, or HSEL=0 with HREADY=1: no data phase; HREADYout=1, HRESP=OKAY.
REQ-019 States: IDLE, WAIT, DATA, ERR1, ERR2.
REQ-020 Accepted legal transfer: next state WAIT if P_WAIT>0 (count P_WAIT cycles, HREADYout=0, HRESP=OKAY), else DATA; WAIT goes to DATA when counter reaches 0.
REQ-021 DATA: HREADYout=1, HRESP=OKAY, for exactly one cycle.
REQ-022 Illegal transfer: HSIZE>2; misaligned (halfword with HADDR[0]=1, word with HADDR[1:0]!=0); HADDR<P_ADDR_BASE; or HADDR+size-1 >= P_ADDR_BASE+P_SIZE_IN_BYTES (compute in 33 bits, no wrap).
REQ-023 Illegal transfer: ERR1 (HREADYout=0, HRESP=ERROR), then ERR2 (HREADYout=1, HRESP=ERROR); ERROR always exactly two cycles regardless of P_WAIT; memory unchanged.
REQ-024 Write: at DATA rising edge, update only lanes selected by latched HSIZE and HADDR[1:0] from same HWDATA lanes (byte: lane=addr[1:0]; halfword: lanes addr[1]*2..+1; word: all).
REQ-025 Read: HRDATA, during DATA, = full 32-bit word at latched word address (all lanes driven); ignored when not in DATA.
REQ-026 Read data phase directly after a write to same word reflects completed write (zero-wait read-after-write coherent; no stale data).
REQ-027 Transfer accepted in last cycle of a data phase (HREADYout=1) is pipelined; DATA->DATA or DATA->WAIT back-to-back with no idle cycle.
REQ-028 Outside data phases HRDATA=32'h0.
REQ-029 Back-to-back burst beats (NONSEQ then SEQ) with P_WAIT=0 complete one beat per cycle.
REQ-030 BUSY received during a burst: no data phase, next beat resumes normally.

Reset
REQ-031 HRESETn=0 asynchronously forces state IDLE, wait counter 0, HREADYout=1, HRESP=OKAY, HRDATA=32'h0.
REQ-032 Reset mid-data-phase aborts the transfer; pending write not committed; memory contents not cleared by reset.
REQ-033 First transfer may be accepted at first rising edge after HRESETn deasserts.

Verification
REQ-034 P_WAIT=0: word write 32'hDEADBEEF @0x10, then read @0x10 -> zero-wait OKAY, HRDATA=32'hDEADBEEF.
REQ-035 Byte write 8'hA5 @0x21 over word 32'h11223344 @0x20 -> read word returns 32'h1122A544.
REQ-036 P_WAIT=3: single read -> HREADYout low exactly 3 cycles, then one OKAY cycle with data.
REQ-037 Word access @0x402 (misaligned) and @P_ADDR_BASE+P_SIZE_IN_BYTES -> ERR1 then ERR2 each; read-back of neighbouring words unchanged.
REQ-038 4-beat INCR word write burst @0x40 then 4-beat read burst (P_WAIT=0) -> 4 consecutive OKAY cycles, data matches, one BUSY inserted mid-read extends burst by exactly one cycle.
REQ-039 HRESETn pulsed low during WAIT of a write -> HREADYout=1 immediately; subsequent read shows old contents.
